burst_ram_responder: RTL and testbench



---
 rtl/burst_ram_responder.sv | 184 ++++++++++++++++++
 tb/tb_burst_ram_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_responder.sv
// Responder end of the br_* burst-RAM interface, backed by an on-chip array.
// Mirrors the external controller's command/busy/valid timing cycle for cycle.
`timescale 1ns/1ps
module burst_ram_responder #(
    parameter int DEPTH_BITWIDTH      = 8,
    parameter int BURST_DATA_COUNT    = 4,
    parameter int BURST_DATA_BITWIDTH = 64,
    parameter int READ_LATENCY        = 4,
    parameter int INIT_CYCLES         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             br_cmd,
    input  logic                             br_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                             br_rd_data_valid,
    output logic                             br_busy
);

    localparam int DEPTH  = 1 << DEPTH_BITWIDTH;
    localparam int MASK_W = BURST_DATA_BITWIDTH / 8;
    localparam int BEAT_W = $clog2(BURST_DATA_COUNT + 1);
    localparam int LAT_W  = $clog2(READ_LATENCY);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_DATA_COUNT - 1);
    localparam logic [BEAT_W-1:0] ALL_BEATS = BEAT_W'(BURST_DATA_COUNT);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE_BURST,
        ST_READ_WAIT,
        ST_READ_BURST
    } state_t;

    state_t                           state_q, state_d;
    logic                             busy_q, busy_d;
    logic                             valid_q, valid_d;
    logic [BURST_DATA_BITWIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DEPTH_BITWIDTH-1:0]        addr_q, addr_d;
    logic [BEAT_W-1:0]                beat_q, beat_d;
    logic [LAT_W-1:0]                 lat_q, lat_d;
    logic [INIT_W-1:0]                init_q, init_d;

    logic                             wr_en;
    logic [DEPTH_BITWIDTH-1:0]        wr_addr;
    logic [DEPTH_BITWIDTH-1:0]        beat_addr;
    logic                             accept;

    logic [BURST_DATA_BITWIDTH-1:0]   mem_q [DEPTH];

    // Beat i of the current burst lives at captured address + i, wrapping silently.
    assign beat_addr = addr_q + DEPTH_BITWIDTH'(beat_q);
    assign accept    = br_cmd_en && !busy_q;

    // NOTE: every signal gets a default at the top of this block so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        init_d    = init_q;
        wr_en     = 1'b0;
        wr_addr   = beat_addr;

        case (state_q)
            ST_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    init_d  = '0;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    addr_d = br_addr;
                    busy_d = 1'b1;
                    if (br_cmd) begin
                        // Beat 0 is written in the accept cycle straight from the ports.
                        wr_en   = 1'b1;
                        wr_addr = br_addr;
                        beat_d  = BEAT_W'(1);
                        state_d = ST_WRITE_BURST;
                    end else begin
                        lat_d   = LAT_W'(1);
                        state_d = ST_READ_WAIT;
                    end
                end
            end

            ST_WRITE_BURST: begin
                wr_en = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            ST_READ_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    valid_d   = 1'b1;
                    rd_data_d = mem_q[beat_addr];
                    beat_d    = BEAT_W'(1);
                    lat_d     = '0;
                    state_d   = ST_READ_BURST;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            ST_READ_BURST: begin
                if (beat_q == ALL_BEATS) begin
                    valid_d   = 1'b0;
                    rd_data_d = '0;
                    busy_d    = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    rd_data_d = mem_q[beat_addr];
                    beat_d    = beat_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
                busy_d  = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            init_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            init_q    <= init_d;
        end
    end

    // NOTE: the array has no reset; its contents must survive rst and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < MASK_W; j++) begin
                if (!br_data_mask[j]) begin
                    mem_q[wr_addr][j*8 +: 8] <= br_wr_data[j*8 +: 8];
                end
            end
        end
    end

    assign br_rd_data       = rd_data_q;
    assign br_rd_data_valid = valid_q;
    assign br_busy          = busy_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder: directed vector table, hand-written
// reset-mid-read sequence, and randomized bursts checked against an array model.
`timescale 1ns/1ps
module tb_burst_ram_responder;

    localparam int AW = 8;
    localparam int BC = 4;
    localparam int DW = 64;
    localparam int RL = 4;
    localparam int IC = 16;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          br_cmd = 1'b0;
    logic          br_cmd_en = 1'b0;
    logic [AW-1:0] br_addr = '0;
    logic [DW-1:0] br_wr_data = '0;
    logic [MW-1:0] br_data_mask = '0;
    logic [DW-1:0] br_rd_data;
    logic          br_rd_data_valid;
    logic          br_busy;

    always #5 clk = ~clk;

    burst_ram_responder #(
        .DEPTH_BITWIDTH      (AW),
        .BURST_DATA_COUNT    (BC),
        .BURST_DATA_BITWIDTH (DW),
        .READ_LATENCY        (RL),
        .INIT_CYCLES         (IC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    typedef logic [BC-1:0][DW-1:0] burst_t;
    typedef logic [BC-1:0][MW-1:0] masks_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        burst_t        data;
        masks_t        mask;
        burst_t        exp;
        logic [3:0]    poke;
    } vec_t;

    localparam logic [DW-1:0] H1 = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] H2 = 64'h2222_2222_2222_2222;
    localparam logic [DW-1:0] H3 = 64'h3333_3333_3333_3333;
    localparam logic [DW-1:0] H4 = 64'h4444_4444_4444_4444;
    localparam logic [DW-1:0] FS = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] WA = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [DW-1:0] WB = 64'hB1B1_B1B1_B1B1_B1B1;
    localparam logic [DW-1:0] WC = 64'hC2C2_C2C2_C2C2_C2C2;
    localparam logic [DW-1:0] WD = 64'hD3D3_D3D3_D3D3_D3D3;
    localparam logic [DW-1:0] P0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] P1 = 64'h1000_0000_0000_0001;
    localparam logic [DW-1:0] P2 = 64'h2000_0000_0000_0002;
    localparam logic [DW-1:0] P3 = 64'h3000_0000_0000_0003;
    localparam logic [DW-1:0] Q0 = 64'h3030_0000_0000_0000;
    localparam logic [DW-1:0] Q1 = 64'h3030_0000_0000_0001;
    localparam logic [DW-1:0] Q2 = 64'h3030_0000_0000_0002;
    localparam logic [DW-1:0] Q3 = 64'h3030_0000_0000_0003;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem_m [2**AW];
    vec_t          vecs [12];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, DW'(act), DW'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic wr, input logic [AW-1:0] a, input burst_t d,
                                 input masks_t m, input burst_t e, input logic [3:0] p);
        vec_t v;
        v.wr   = wr;
        v.addr = a;
        v.data = d;
        v.mask = m;
        v.exp  = e;
        v.poke = p;
        return v;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (br_busy && n < 200) begin
            tick();
            n++;
        end
        check1({tag, " idle_wait"}, br_busy, 1'b0);
    endtask

    // Issues one write burst and checks the busy profile; the model array follows the byte masks.
    task automatic do_write(input logic [AW-1:0] addr, input burst_t d, input masks_t m, input string tag);
        wait_idle(tag);
        br_cmd_en = 1'b1;
        br_cmd    = 1'b1;
        br_addr   = addr;
        for (int i = 0; i < BC; i++) begin
            logic [AW-1:0] a;
            a = addr + AW'(i);
            if (i > 0) check1($sformatf("%s wr busy k+%0d", tag, i), br_busy, 1'b1);
            br_wr_data   = d[i];
            br_data_mask = m[i];
            for (int j = 0; j < MW; j++)
                if (!m[i][j]) mem_m[a][j*8 +: 8] = d[i][j*8 +: 8];
            tick();
            br_cmd_en = 1'b0;
        end
        check1({tag, " wr busy low k+4"}, br_busy, 1'b0);
        check1({tag, " wr no valid"}, br_rd_data_valid, 1'b0);
    endtask

    // Issues one read burst and checks busy/valid/data in every cycle up to the first idle cycle.
    // A nonzero poke drives a write command at 0x30 in cycle k+poke, which must be ignored.
    task automatic do_read(input logic [AW-1:0] addr, input burst_t exp, input logic [3:0] poke, input string tag);
        wait_idle(tag);
        br_cmd_en = 1'b1;
        br_cmd    = 1'b0;
        br_addr   = addr;
        tick();
        br_cmd_en = 1'b0;
        for (int c = 1; c <= RL + BC; c++) begin
            logic          in_w;
            logic [DW-1:0] e;
            in_w = (c >= RL) && (c < RL + BC);
            e    = '0;
            if (in_w) e = exp[c-RL];
            check1($sformatf("%s rd busy k+%0d", tag, c), br_busy, c < RL + BC);
            check1($sformatf("%s rd valid k+%0d", tag, c), br_rd_data_valid, in_w);
            check($sformatf("%s rd data k+%0d", tag, c), br_rd_data, e);
            if (c == int'(poke)) begin
                br_cmd_en    = 1'b1;
                br_cmd       = 1'b1;
                br_addr      = 8'h30;
                br_wr_data   = '1;
                br_data_mask = '0;
            end
            if (c < RL + BC) begin
                tick();
                br_cmd_en = 1'b0;
            end
        end
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c <= IC; c++) begin
            check1($sformatf("%s init busy c%0d", tag, c), br_busy, c < IC);
            check1($sformatf("%s init valid c%0d", tag, c), br_rd_data_valid, 1'b0);
            check($sformatf("%s init data c%0d", tag, c), br_rd_data, '0);
            if (c < IC) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1);
    end

    initial begin
        burst_t rd_e;
        burst_t wd;
        masks_t wm;

        // Beat 3 is leftmost in every concatenation below.
        vecs[0]  = mkv(1'b1, 8'h10, {H4, H3, H2, H1}, '0, '0, 4'd0);
        vecs[1]  = mkv(1'b0, 8'h10, '0, '0, {H4, H3, H2, H1}, 4'd0);
        vecs[2]  = mkv(1'b1, 8'h20, {FS, FS, FS, FS}, '0, '0, 4'd0);
        vecs[3]  = mkv(1'b1, 8'h20, '0, {8'hFF, 8'hFF, 8'hFF, 8'hF0}, '0, 4'd0);
        vecs[4]  = mkv(1'b0, 8'h20, '0, '0, {FS, FS, FS, 64'hFFFF_FFFF_0000_0000}, 4'd0);
        vecs[5]  = mkv(1'b1, 8'h00, {P3, P2, P1, P0}, '0, '0, 4'd0);
        vecs[6]  = mkv(1'b1, 8'hFE, {WD, WC, WB, WA}, '0, '0, 4'd0);
        vecs[7]  = mkv(1'b0, 8'hFE, '0, '0, {WD, WC, WB, WA}, 4'd0);
        vecs[8]  = mkv(1'b0, 8'h00, '0, '0, {P3, P2, WD, WC}, 4'd0);
        vecs[9]  = mkv(1'b1, 8'h30, {Q3, Q2, Q1, Q0}, '0, '0, 4'd0);
        vecs[10] = mkv(1'b0, 8'h10, '0, '0, {H4, H3, H2, H1}, 4'd2);
        vecs[11] = mkv(1'b0, 8'h30, '0, '0, {Q3, Q2, Q1, Q0}, 4'd0);

        reset_and_check("por");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, $sformatf("vec%0d", i));
            else            do_read(vecs[i].addr, vecs[i].exp, vecs[i].poke, $sformatf("vec%0d", i));
        end

        // Reset during the second valid beat of a read of 0x10.
        wait_idle("midrd");
        br_cmd_en = 1'b1;
        br_cmd    = 1'b0;
        br_addr   = 8'h10;
        tick();
        br_cmd_en = 1'b0;
        repeat (4) tick();
        check1("midrd valid k+5", br_rd_data_valid, 1'b1);
        check("midrd data k+5", br_rd_data, H2);
        rst = 1'b1;
        #1;
        check1("midrd async valid", br_rd_data_valid, 1'b0);
        check("midrd async data", br_rd_data, '0);
        check1("midrd async busy", br_busy, 1'b1);
        reset_and_check("midrd");
        do_read(8'h10, {H4, H3, H2, H1}, 4'd0, "retained");

        // Random phase: prefill a region, then mixed bursts against the model array.
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < BC; i++) wd[i] = {$urandom, $urandom};
            do_write(AW'(8'h40 + 4 * b), wd, '0, $sformatf("fill%0d", b));
        end
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            a = AW'(8'h40 + $urandom_range(0, 60));
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < BC; i++) begin
                    wd[i] = {$urandom, $urandom};
                    wm[i] = ($urandom_range(0, 2) == 0) ? MW'($urandom) : '0;
                end
                do_write(a, wd, wm, $sformatf("rnd%0d", n));
            end else begin
                for (int i = 0; i < BC; i++) rd_e[i] = mem_m[a + AW'(i)];
                do_read(a, rd_e, 4'd0, $sformatf("rnd%0d", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
